// File: rtl/exec_cc_stage.sv
// Y86-64 execute-stage back end: condition-code register, branch/cmov
// condition evaluation, and the E->M pipeline register.
module exec_cc_stage #(
    parameter int          W     = 64,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    E_stat,
    input  logic [3:0]    E_icode,
    input  logic [3:0]    E_ifun,
    input  logic [W-1:0]  E_valA,
    input  logic [3:0]    E_dstE,
    input  logic [3:0]    E_dstM,
    input  logic [W-1:0]  alu_out,
    input  logic          alu_of,
    input  logic [3:0]    m_stat,
    input  logic [3:0]    W_stat,
    input  logic          M_stall,
    input  logic          M_bubble,
    output logic          e_Cnd,
    output logic [3:0]    e_dstE,
    output logic [2:0]    cc_out,
    output logic [3:0]    M_stat,
    output logic [3:0]    M_icode,
    output logic          M_Cnd,
    output logic [W-1:0]  M_valE,
    output logic [W-1:0]  M_valA,
    output logic [3:0]    M_dstE,
    output logic [3:0]    M_dstM
);

    localparam logic [3:0] SAOK    = 4'd1;
    localparam logic [3:0] SHLT    = 4'd2;
    localparam logic [3:0] SADR    = 4'd3;
    localparam logic [3:0] SINS    = 4'd4;
    localparam logic [3:0] ICMOVXX = 4'd2;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] INOP    = 4'd1;

    logic [2:0] cc_q;
    logic [2:0] cc_new;
    logic       set_cc;
    logic       zf, sf, of;
    logic       m_exc, w_exc;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    assign cc_new = {(alu_out == '0), alu_out[W-1], alu_of};

    // An excepting instruction downstream must not let younger OPq's alter state.
    assign m_exc  = (m_stat == SHLT) || (m_stat == SADR) || (m_stat == SINS);
    assign w_exc  = (W_stat == SHLT) || (W_stat == SADR) || (W_stat == SINS);
    assign set_cc = (E_icode == IOPQ) && !m_exc && !w_exc;

    always_comb begin
        e_Cnd = 1'b0;
        unique case (E_ifun)
            4'd0:    e_Cnd = 1'b1;
            4'd1:    e_Cnd = (sf ^ of) | zf;
            4'd2:    e_Cnd = sf ^ of;
            4'd3:    e_Cnd = zf;
            4'd4:    e_Cnd = ~zf;
            4'd5:    e_Cnd = ~(sf ^ of);
            4'd6:    e_Cnd = ~(sf ^ of) & ~zf;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_dstE = ((E_icode == ICMOVXX) && !e_Cnd) ? RNONE : E_dstE;
    assign cc_out = cc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= 3'b100;
        end else if (set_cc) begin
            cc_q <= cc_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || M_bubble) begin
            M_stat  <= SAOK;
            M_icode <= INOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= alu_out;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule

// File: tb/tb_exec_cc_stage.sv
// Directed-vector bench for exec_cc_stage: CC update, condition table,
// cmov squash, exception suppression, stall/bubble and async reset.
module tb_exec_cc_stage;

    localparam int W = 64;

    logic          clk;
    logic          rst;
    logic [3:0]    E_stat, E_icode, E_ifun, E_dstE, E_dstM;
    logic [W-1:0]  E_valA, alu_out;
    logic          alu_of;
    logic [3:0]    m_stat, W_stat;
    logic          M_stall, M_bubble;
    logic          e_Cnd;
    logic [3:0]    e_dstE;
    logic [2:0]    cc_out;
    logic [3:0]    M_stat, M_icode, M_dstE, M_dstM;
    logic          M_Cnd;
    logic [W-1:0]  M_valE, M_valA;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    exec_cc_stage #(.W(W), .RNONE(4'hF)) dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .alu_out(alu_out), .alu_of(alu_of),
        .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_Cnd(e_Cnd), .e_dstE(e_dstE), .cc_out(cc_out),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        E_stat = 4'd1; E_icode = 4'd1; E_ifun = 4'd0; E_valA = '0;
        E_dstE = 4'hF; E_dstM = 4'hF; alu_out = 64'd1; alu_of = 1'b0;
        m_stat = 4'd1; W_stat = 4'd1; M_stall = 1'b0; M_bubble = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        // reset state
        check("rst_cc",      cc_out,  3'b100);
        check("rst_M_stat",  M_stat,  4'd1);
        check("rst_M_icode", M_icode, 4'd1);
        check("rst_M_Cnd",   M_Cnd,   1'b0);
        check("rst_M_valE",  M_valE,  64'd0);
        check("rst_M_dstE",  M_dstE,  4'hF);
        check("rst_M_dstM",  M_dstM,  4'hF);
        tick();
        rst = 1'b0;

        // OPq with result 5: CC -> 000; condition still uses old CC this cycle
        E_icode = 4'd6; alu_out = 64'd5; E_ifun = 4'd3; #1;
        check("pre_write_Cnd_e", e_Cnd, 1'b1);
        tick();
        check("op5_cc", cc_out, 3'b000);
        check("op5_M_icode", M_icode, 4'd6);
        check("op5_M_valE", M_valE, 64'd5);
        check("op5_M_Cnd", M_Cnd, 1'b1);

        // subq 5-5
        E_ifun = 4'd1; alu_out = 64'd0; alu_of = 1'b0;
        tick();
        check("subq_cc", cc_out, 3'b100);
        E_icode = 4'd7; E_ifun = 4'd3; #1;
        check("subq_je", e_Cnd, 1'b1);
        E_ifun = 4'd4; #1;
        check("subq_jne", e_Cnd, 1'b0);

        // signed overflow
        E_icode = 4'd6; E_ifun = 4'd0; alu_out = 64'h8000_0000_0000_0000; alu_of = 1'b1;
        tick();
        check("ovf_cc", cc_out, 3'b011);
        E_icode = 4'd7; alu_of = 1'b0;
        E_ifun = 4'd2; #1; check("ovf_jl",  e_Cnd, 1'b0);
        E_ifun = 4'd5; #1; check("ovf_jge", e_Cnd, 1'b1);
        E_ifun = 4'd1; #1; check("ovf_jle", e_Cnd, 1'b0);
        E_ifun = 4'd6; #1; check("ovf_jg",  e_Cnd, 1'b1);
        E_ifun = 4'd0; #1; check("ovf_jmp", e_Cnd, 1'b1);
        E_ifun = 4'd8; #1; check("ovf_if8", e_Cnd, 1'b0);

        // cmov squash with ZF=0
        E_icode = 4'd2; E_ifun = 4'd3; E_dstE = 4'h3; alu_out = 64'd77; #1;
        check("cmov0_e_dstE", e_dstE, 4'hF);
        tick();
        check("cmov0_M_dstE", M_dstE, 4'hF);
        check("cmov0_M_Cnd",  M_Cnd,  1'b0);
        check("cmov0_cc_hold", cc_out, 3'b011);
        // set ZF, then repeat
        E_icode = 4'd6; E_ifun = 4'd1; alu_out = 64'd0; E_dstE = 4'hF;
        tick();
        check("zf_cc", cc_out, 3'b100);
        E_icode = 4'd2; E_ifun = 4'd3; E_dstE = 4'h3; alu_out = 64'd77; #1;
        check("cmov1_e_dstE", e_dstE, 4'h3);
        tick();
        check("cmov1_M_dstE", M_dstE, 4'h3);
        check("cmov1_M_Cnd",  M_Cnd,  1'b1);
        check("cmov1_M_valE", M_valE, 64'd77);

        // exception suppression
        E_icode = 4'd6; E_ifun = 4'd0; E_dstE = 4'hF;
        alu_out = 64'hFFFF_FFFF_FFFF_FFFF; m_stat = 4'd3;
        tick();
        check("exc_m_cc", cc_out, 3'b100);
        m_stat = 4'd1; W_stat = 4'd4;
        tick();
        check("exc_w_cc", cc_out, 3'b100);
        m_stat = 4'd2; W_stat = 4'd1;
        tick();
        check("exc_hlt_cc", cc_out, 3'b100);
        m_stat = 4'd1;
        tick();
        check("noexc_cc", cc_out, 3'b010);

        // stall / bubble
        E_icode = 4'd3; alu_out = 64'h1234; E_valA = 64'h55; E_dstE = 4'h2; E_dstM = 4'h7;
        tick();
        check("load_M_valE",  M_valE,  64'h1234);
        check("load_M_valA",  M_valA,  64'h55);
        check("load_M_dstM",  M_dstM,  4'h7);
        check("load_M_icode", M_icode, 4'd3);
        M_stall = 1'b1; E_icode = 4'd6; alu_out = 64'd0; E_valA = 64'h99;
        tick();
        check("stall_M_valE",  M_valE,  64'h1234);
        check("stall_M_icode", M_icode, 4'd3);
        check("stall_M_valA",  M_valA,  64'h55);
        check("stall_cc_upd",  cc_out,  3'b100);
        M_bubble = 1'b1; E_icode = 4'd3; alu_out = 64'h4321;
        tick();
        check("bub_M_icode", M_icode, 4'd1);
        check("bub_M_valE",  M_valE,  64'd0);
        check("bub_M_dstE",  M_dstE,  4'hF);
        check("bub_M_dstM",  M_dstM,  4'hF);
        M_stall = 1'b0; M_bubble = 1'b0;

        // async reset mid-stream discards pending CC write and M contents
        E_icode = 4'd6; alu_out = 64'd5; E_dstE = 4'h4;
        tick();
        check("pre_rst_cc", cc_out, 3'b000);
        check("pre_rst_M_icode", M_icode, 4'd6);
        alu_out = 64'd0;
        #2 rst = 1'b1;
        #1;
        check("arst_cc",      cc_out,  3'b100);
        check("arst_M_icode", M_icode, 4'd1);
        check("arst_M_dstE",  M_dstE,  4'hF);
        check("arst_M_dstM",  M_dstM,  4'hF);
        alu_out = 64'd5;
        tick();
        check("arst_hold_cc", cc_out, 3'b100);
        check("arst_hold_M_valE", M_valE, 64'd0);
        idle_inputs();
        #1 rst = 1'b0;
        tick();
        check("post_rst_cc", cc_out, 3'b100);
        check("post_rst_M_icode", M_icode, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
